// File: rtl/sccb_arbiter.sv
// sccb_arbiter: round-robin arbiter sharing one SCCB write engine between two requesters.
// Define SCCB_ARB_TIMEOUT_EN to build the per-transaction watchdog (tout); otherwise tout is tied low.
module sccb_arbiter #(
    parameter logic [7:0]  DEV_ADDR  = 8'h42,
    parameter logic [23:0] TO_CYCLES = 24'd2_500_000
) (
    input  logic        clk_25M,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [1:0]  nack,
    output logic [1:0]  tout,
    output logic        busy,
    output logic        i2c_start,
    output logic [23:0] i2c_data,
    input  logic        i2c_tr_end,
    input  logic        i2c_ack
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_END, RELEASE} state_t;

    state_t      state, state_nxt;
    logic        tr_p0, tr_s;
    logic        ack_p0, ack_s;
    logic        last, last_nxt;
    logic        pick;
    logic        start_r, start_nxt;
    logic [1:0]  gnt_nxt;
    logic [23:0] data_nxt;
    logic        fin;
    logic        to_hit;

    // Engine flags come from the 20 kHz domain
    always_ff @(posedge clk_25M or negedge reset) begin
        if (!reset) begin
            tr_p0  <= 1'b0;
            tr_s   <= 1'b0;
            ack_p0 <= 1'b0;
            ack_s  <= 1'b0;
        end else begin
            tr_p0  <= i2c_tr_end;
            tr_s   <= tr_p0;
            ack_p0 <= i2c_ack;
            ack_s  <= ack_p0;
        end
    end

`ifdef SCCB_ARB_TIMEOUT_EN
    logic [23:0] to_cnt;

    always_ff @(posedge clk_25M or negedge reset) begin
        if (!reset) begin
            to_cnt <= 24'd0;
        end else if (state == IDLE && state_nxt == ISSUE) begin
            to_cnt <= 24'd0;
        end else if (state == WAIT_END || state == RELEASE) begin
            to_cnt <= to_cnt + 24'd1;
        end
    end

    assign to_hit = (state == WAIT_END || state == RELEASE) && (to_cnt == TO_CYCLES - 24'd1);
    assign tout   = to_hit ? gnt : 2'b00;
`else
    assign to_hit = 1'b0;
    assign tout   = 2'b00;
`endif

    // On a tie the requester not served last wins
    assign pick = (req == 2'b11) ? ~last : req[1];

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        data_nxt  = i2c_data;
        last_nxt  = last;
        start_nxt = start_r;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nxt = ISSUE;
                    gnt_nxt   = pick ? 2'b10 : 2'b01;
                    data_nxt  = {DEV_ADDR, (pick ? wdata1 : wdata0)};
                    last_nxt  = pick;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_END;
                start_nxt = 1'b1;
            end
            WAIT_END: begin
                if (tr_s) begin
                    state_nxt = RELEASE;
                    start_nxt = 1'b0;
                end
            end
            RELEASE: begin
                fin = !tr_s;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (fin || to_hit) begin
            state_nxt = IDLE;
            gnt_nxt   = 2'b00;
            start_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_25M or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            i2c_data <= 24'h0;
            last     <= 1'b1;
            start_r  <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            i2c_data <= data_nxt;
            last     <= last_nxt;
            start_r  <= start_nxt;
        end
    end

    // Completion flags are qualified by the live grant so they only reach the owner
    assign done      = (fin || to_hit) ? gnt : 2'b00;
    assign nack      = (fin && !to_hit && ack_s) ? gnt : 2'b00;
    assign i2c_start = start_r & ~to_hit;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sccb_arbiter.sv
// Self-checking bench for sccb_arbiter: directed SCCB scenarios plus randomized round-robin traffic.
`timescale 1ns/1ps
module tb_sccb_arbiter;

    localparam logic [7:0] DEV = 8'h42;
    localparam int         TO  = 100;

    logic        clk_25M = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] wdata0, wdata1;
    logic [1:0]  gnt, done, nack, tout;
    logic        busy, i2c_start;
    logic [23:0] i2c_data;
    logic        i2c_tr_end, i2c_ack;

    always #20 clk_25M = ~clk_25M;

    sccb_arbiter #(.DEV_ADDR(DEV), .TO_CYCLES(24'd100)) dut (
        .clk_25M    (clk_25M),
        .reset      (reset),
        .req        (req),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .gnt        (gnt),
        .done       (done),
        .nack       (nack),
        .tout       (tout),
        .busy       (busy),
        .i2c_start  (i2c_start),
        .i2c_data   (i2c_data),
        .i2c_tr_end (i2c_tr_end),
        .i2c_ack    (i2c_ack)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int eng_delay = 10;
    bit eng_ack   = 1'b0;
    bit eng_hang  = 1'b0;
    int eng_cnt   = 0;
    int ref_last  = 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    // Reference arbitration: a tie goes to whoever was not served last
    function automatic int ref_pick(input logic [1:0] r);
        int w;
        if (r == 2'b11) w = 1 - ref_last;
        else            w = r[1] ? 1 : 0;
        ref_last = w;
        return w;
    endfunction

    // Engine model: raises tr_end eng_delay cycles after start, drops it once start falls
    initial begin
        i2c_tr_end = 1'b0;
        i2c_ack    = 1'b0;
        forever begin
            @(negedge clk_25M);
            if (!reset) begin
                eng_cnt    = 0;
                i2c_tr_end = 1'b0;
            end else if (eng_hang) begin
                eng_cnt = 0;
            end else if (i2c_start && !i2c_tr_end) begin
                eng_cnt++;
                if (eng_cnt >= eng_delay) begin
                    i2c_tr_end = 1'b1;
                    i2c_ack    = eng_ack;
                    eng_cnt    = 0;
                end
            end else if (!i2c_start && i2c_tr_end) begin
                i2c_tr_end = 1'b0;
            end
        end
    end

    // Called at a negedge with the DUT idle; checks grant one cycle later and start two cycles later
    task automatic start_txn(input logic [1:0] r, output int w, output logic [23:0] ed);
        req = r;
        w   = ref_pick(r);
        ed  = {DEV, ((w == 1) ? wdata1 : wdata0)};
        @(negedge clk_25M);
        check("grant", 32'(gnt), 32'(onehot(w)));
        check("busy_issue", 32'(busy), 32'd1);
        check("start_not_yet", 32'(i2c_start), 32'd0);
        check("data_latched", 32'(i2c_data), 32'(ed));
        @(negedge clk_25M);
        check("start_latency", 32'(i2c_start), 32'd1);
    endtask

    task automatic wait_done(input int w, input logic [23:0] ed, input bit exp_nack,
                             input int budget, input logic [1:0] req_after);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk_25M);
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("flags_granted_only", 32'((done | nack | tout) & ~gnt), 32'd0);
            if (done != 2'b00) seen = 1'b1;
        end
        check("done_within_budget", 32'(seen), 32'd1);
        if (seen) begin
            check("done", 32'(done), 32'(onehot(w)));
            check("nack", 32'(nack), exp_nack ? 32'(onehot(w)) : 32'd0);
            check("tout", 32'(tout), 32'd0);
            check("data_at_done", 32'(i2c_data), 32'(ed));
            req = req_after;
            @(negedge clk_25M);
            check("done_one_cycle", 32'(done), 32'd0);
            check("gnt_released", 32'(gnt), 32'd0);
            check("busy_idle", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [23:0] ed;
        logic [1:0]  r;

        reset = 1'b0; req = 2'b00; wdata0 = 16'h0; wdata1 = 16'h0;
        repeat (3) @(negedge clk_25M);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_nack", 32'(nack), 32'd0);
        check("rst_tout", 32'(tout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(i2c_start), 32'd0);
        check("rst_data", 32'(i2c_data), 32'd0);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk_25M);
            check("idle_quiet", 32'({gnt, done, nack, tout, busy, i2c_start}), 32'd0);
        end

        // Single request, dropped while granted
        wdata0 = 16'h1280; eng_delay = 1000; eng_ack = 1'b0;
        start_txn(2'b01, w, ed);
        req = 2'b00;
        wait_done(w, 24'h421280, 1'b0, 1100, 2'b00);

        // Tie straight out of reset: requester 0 first, then 1 with one idle cycle
        reset = 1'b0; @(negedge clk_25M); reset = 1'b1; ref_last = 1;
        wdata0 = 16'($urandom); wdata1 = 16'($urandom); eng_delay = 20;
        start_txn(2'b11, w, ed);
        check("tie_first_is_0", 32'(gnt), 32'h1);
        wait_done(w, ed, 1'b0, 200, 2'b11);
        start_txn(2'b11, w, ed);
        check("tie_second_is_1", 32'(gnt), 32'h2);
        req = 2'b00;
        wait_done(w, ed, 1'b0, 200, 2'b00);

        // NACK on requester 1 with wdata changed after grant
        wdata1 = 16'h1101; eng_ack = 1'b1; eng_delay = 50;
        start_txn(2'b10, w, ed);
        wdata1 = 16'h1103;
        repeat (5) @(negedge clk_25M);
        check("data_hold", 32'(i2c_data), 32'h421101);
        wait_done(w, 24'h421101, 1'b1, 200, 2'b00);

        // Randomized traffic against the round-robin model
        for (int i = 0; i < 24; i++) begin
            r = 2'($urandom_range(1, 3));
            wdata0 = 16'($urandom); wdata1 = 16'($urandom);
            eng_delay = $urandom_range(1, 40);
            eng_ack = 1'($urandom_range(0, 1));
            start_txn(r, w, ed);
            wdata0 = 16'($urandom); wdata1 = 16'($urandom);
            if ($urandom_range(0, 1) == 1) req = 2'b00;
            wait_done(w, ed, eng_ack, 200, 2'b00);
        end

        // Reset while waiting on the engine
        wdata0 = 16'h3a5c; eng_delay = 500; eng_ack = 1'b0;
        start_txn(2'b01, w, ed);
        repeat (10) @(negedge clk_25M);
        #5 reset = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_start", 32'(i2c_start), 32'd0);
        check("arst_data", 32'(i2c_data), 32'd0);
        req = 2'b00;
        repeat (3) begin
            @(negedge clk_25M);
            check("arst_no_done", 32'({done, nack, tout}), 32'd0);
        end
        reset = 1'b1; ref_last = 1;
        wdata0 = 16'h5501; wdata1 = 16'h5502; eng_delay = 15;
        start_txn(2'b11, w, ed);
        check("post_rst_tie_0", 32'(gnt), 32'h1);
        req = 2'b00;
        wait_done(w, 24'h425501, 1'b0, 200, 2'b00);

`ifdef SCCB_ARB_TIMEOUT_EN
        begin
            int  k;
            bit  seen;
            eng_hang = 1'b1;
            wdata0 = 16'h0a0b;
            start_txn(2'b01, w, ed);
            req = 2'b00;
            k = 1; seen = 1'b0;
            while (!seen && k < TO + 20) begin
                @(negedge clk_25M);
                k++;
                if (done != 2'b00) seen = 1'b1;
                else check("to_start_held", 32'(i2c_start), 32'd1);
            end
            check("to_seen", 32'(seen), 32'd1);
            check("to_cycle", 32'(k), 32'(TO));
            check("to_done", 32'(done), 32'h1);
            check("to_tout", 32'(tout), 32'h1);
            check("to_nack", 32'(nack), 32'd0);
            check("to_start_low", 32'(i2c_start), 32'd0);
            @(negedge clk_25M);
            check("to_idle", 32'({gnt, done, tout, busy}), 32'd0);
            eng_hang = 1'b0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sccb_arbiter.md
SCCB_ARBITER -- requirements
Module: sccb_arbiter

Interface
REQ-001 Parameter DEV_ADDR, default 8'h42, SCCB write device address placed in i2c_data[23:16].
REQ-002 Parameter TO_CYCLES, default 24'd2_500_000, clk_25M cycles allowed per transaction, about 100 ms.
REQ-003 clk_25M  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-005 req  input  2  per-requester level request (bit0 = boot config sequencer, bit1 = runtime register writer).
REQ-006 wdata0, wdata1  input  16 each  {reg_addr, reg_val} for requester 0 and requester 1.
REQ-007 gnt  output  2  one-hot grant, held for the whole transaction.
REQ-008 done  output  2  one-cycle completion pulse per requester.
REQ-009 nack  output  2  one-cycle pulse coincident with done when the slave did not acknowledge.
REQ-010 tout  output  2  one-cycle pulse coincident with done on watchdog expiry.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 i2c_start  output  1  drives the shared SCCB engine start input.
REQ-013 i2c_data  output  24  {DEV_ADDR, latched wdata} to the engine.
REQ-014 i2c_tr_end  input  1  engine end-of-transfer flag, asynchronous to clk_25M (20 kHz domain).
REQ-015 i2c_ack  input  1  engine acknowledge flag, high = NACK, asynchronous to clk_25M.

Function
REQ-016 i2c_tr_end and i2c_ack shall each pass through a 2-flop synchronizer; all decisions use the synchronized copies tr_s and ack_s.
REQ-017 FSM states shall be IDLE, ISSUE, WAIT_END, RELEASE.
REQ-018 IDLE with req==0 shall remain in IDLE with all outputs low.
REQ-019 IDLE with req!=0 shall pick a winner by round-robin and move to ISSUE on the next edge.
REQ-020 Round-robin rule: when both bits request, the requester not served last wins; otherwise the sole requester wins. The last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-021 On the IDLE->ISSUE edge the block shall set gnt, latch the winner's wdata into i2c_data, and update the last-served pointer.
REQ-022 ISSUE shall assert i2c_start and move to WAIT_END on the next edge.
REQ-023 WAIT_END shall hold i2c_start high and i2c_data stable until tr_s==1, then clear i2c_start and move to RELEASE.
REQ-024 In RELEASE, when tr_s==0 the block shall pulse done[winner] for one cycle, set nack[winner]=ack_s sampled in that cycle, clear gnt, and return to IDLE.
REQ-025 A request dropped while granted shall not abort the transaction; done is still pulsed.
REQ-026 A request arriving mid-transaction shall wait; it is arbitrated in the first IDLE cycle, with no idle gap beyond one cycle.
REQ-027 Changes to wdata after grant shall have no effect on the transaction.
REQ-028 gnt shall be one-hot or zero at all times; done, nack and tout shall never be set for a non-granted requester.
REQ-029 Latency from req to i2c_start high shall be exactly 2 clk_25M cycles when IDLE.

Reset
REQ-030 Reset low shall force state to IDLE, gnt=0, done=0, nack=0, tout=0, busy=0, i2c_start=0, i2c_data=24'h0, last-served pointer=1, and clear the synchronizers and watchdog counter.
REQ-031 Reset mid-transaction shall discard the transaction with no done pulse; after release the block behaves as from power-up.

Configuration
REQ-032 Macro SCCB_ARB_TIMEOUT_EN defined: a counter clears on entry to ISSUE and increments in WAIT_END and RELEASE. Reaching TO_CYCLES-1 shall drop i2c_start, pulse done[winner] and tout[winner], and return to IDLE.
REQ-033 Macro SCCB_ARB_TIMEOUT_EN undefined: no counter is built, tout is tied 2'b00, and WAIT_END/RELEASE wait indefinitely.

Verification
REQ-034 Single request: req=2'b01, wdata0=16'h1280; engine model raises tr_end after 1000 cycles with ack=0 -> i2c_data=24'h421280, start high 2 cycles after req, done=2'b01 pulse, nack=0.
REQ-035 Tie: req=2'b11 from reset -> requester 0 served first, then requester 1 immediately after; gnt never 2'b11.
REQ-036 NACK: engine model returns ack=1 at tr_end -> done[1] and nack[1] pulse in the same cycle.
REQ-037 Data change after grant: wdata1 changes from 16'h1101 to 16'h1103 while gnt[1]=1 -> i2c_data stays 24'h421101.
REQ-038 Timeout (macro defined, TO_CYCLES=100): tr_end never rises -> i2c_start falls and done[0] and tout[0] pulse at cycle 100 after ISSUE.
REQ-039 Reset asserted during WAIT_END -> all outputs 0 asynchronously and no done pulse; a new req after release is served normally.
